cmp1_self_test: RTL

On-board self-test sequencer for a 1-bit magnitude comparator (inputs a, b; outputs a_gt_b, a_eq_b, a_lt_b). It drives all four input vectors into the comparator under test, waits a settle interval, and checks the three result lines against the expected one-hot response. It reports pass/fail and a per-vector failure mask for LEDs or a host register. It sits beside the comparator in the lab top level, in the same clock domain.

---
 rtl/cmp_pkg.sv | 21 ++
 rtl/cmp_expect.sv | 16 +
 rtl/cmp1_self_test.sv | 113 +++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the 1-bit comparator self-test sequencer and its golden model.
package cmp_pkg;

    localparam int unsigned NUM_VECTORS = 4;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned SETTLE_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_result_t;

endpackage

// File: rtl/cmp_expect.sv
// Combinational golden model of a 1-bit magnitude comparator.
module cmp_expect
    import cmp_pkg::*;
(
    input  logic        a,
    input  logic        b,
    output cmp_result_t result_c
);

    always_comb begin
        result_c.gt = a & ~b;
        result_c.eq = ~(a ^ b);
        result_c.lt = ~a & b;
    end

endmodule

// File: rtl/cmp1_self_test.sv
// Self-test sequencer: sweeps all four {a,b} vectors into a 1-bit comparator,
// lets each settle, and records per-vector mismatches against the golden model.
module cmp1_self_test
    import cmp_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   drive_a,
    output logic                   drive_b,
    input  logic                   a_gt_b,
    input  logic                   a_eq_b,
    input  logic                   a_lt_b,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [NUM_VECTORS-1:0] fail_vec
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(NUM_VECTORS - 1);

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [SETTLE_W-1:0]    cnt;

    cmp_result_t            exp_c;
    cmp_result_t            got_c;
    logic [NUM_VECTORS-1:0] hit_c;
    logic [NUM_VECTORS-1:0] fail_next_c;
    logic [IDX_W-1:0]       idx_inc_c;

    cmp_expect u_expect (
        .a        (idx[1]),
        .b        (idx[0]),
        .result_c (exp_c)
    );

    // Any deviation on any line (zero-hot, multi-hot, wrong-hot) fails the vector.
    always_comb begin
        got_c.gt    = a_gt_b;
        got_c.eq    = a_eq_b;
        got_c.lt    = a_lt_b;
        hit_c       = '0;
        hit_c[idx]  = (got_c != exp_c);
        fail_next_c = fail_vec | hit_c;
        idx_inc_c   = idx + IDX_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            cnt      <= '0;
            drive_a  <= 1'b0;
            drive_b  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_vec <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_DRIVE;
                        idx      <= '0;
                        cnt      <= SETTLE_LOAD;
                        fail_vec <= '0;
                        pass     <= 1'b0;
                        busy     <= 1'b1;
                        drive_a  <= 1'b0;
                        drive_b  <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt - SETTLE_W'(1);
                    end
                end
                ST_CHECK: begin
                    // Last vector's result is folded into pass on the same edge.
                    fail_vec <= fail_next_c;
                    if (idx == LAST_IDX) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        pass    <= ~|fail_next_c;
                        drive_a <= 1'b0;
                        drive_b <= 1'b0;
                    end else begin
                        state   <= ST_DRIVE;
                        idx     <= idx_inc_c;
                        cnt     <= SETTLE_LOAD;
                        drive_a <= idx_inc_c[1];
                        drive_b <= idx_inc_c[0];
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
